// File: rtl/ls_mem_req.sv
// Load/store memory request sequencer: issues one bus access per decoded op and returns a result.
// Optional macro LS_MISALIGN_CHECK_EN rejects misaligned halfword/word accesses without a bus cycle.

package Pu_types;
  typedef enum logic [1:0] {Load_null, Load_byte, Load_halfword, Load_word} Load_mode;
endpackage

module ls_mem_req #(
  parameter int unsigned WAIT_MAX = 255
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                en_dec,
  input  logic                we,
  input  Pu_types::Load_mode  mode,
  input  logic                return_dout,
  input  logic                exts,
  input  logic                do_request,
  input  logic [31:0]         addr,
  input  logic [31:0]         wdata,
  output logic                stall,
  output logic                dmem_req,
  output logic                dmem_we,
  output logic [31:0]         dmem_addr,
  output logic [3:0]          dmem_be,
  output logic [31:0]         dmem_wdata,
  input  logic                dmem_ack,
  input  logic                dmem_rvalid,
  input  logic                dmem_err,
  input  logic [31:0]         dmem_rdata,
  output logic                res_valid,
  output logic                res_err,
  output logic [31:0]         res_data
);

  // The counter only needs to reach WAIT_MAX-1; the timeout fires on the cycle it sits there.
  localparam int unsigned CntW = (WAIT_MAX < 2) ? 1 : $clog2(WAIT_MAX);
  localparam logic [CntW-1:0] CntLast = CntW'((WAIT_MAX == 0) ? 0 : WAIT_MAX - 1);

  typedef enum logic [1:0] {StIdle, StReq, StWait} state_e;

  state_e             state_q, state_d;
  logic [CntW-1:0]    cnt_q, cnt_d;
  logic [31:0]        addr_q, addr_d;
  logic               we_q, we_d;
  Pu_types::Load_mode mode_q, mode_d;
  logic               exts_q, exts_d;
  logic               ret_q, ret_d;
  logic [3:0]         be_q, be_d;
  logic [31:0]        wdata_q, wdata_d;
  logic               res_valid_q, res_valid_d;
  logic               res_err_q, res_err_d;
  logic [31:0]        res_data_q, res_data_d;

  logic               misalign;
  logic               timeout;
  logic [31:0]        load_data;
  logic [31:0]        load_result;

  function automatic logic [3:0] lane_be(input Pu_types::Load_mode m, input logic [1:0] a);
    logic [3:0] be;
    case (m)
      Pu_types::Load_byte:     be = 4'b1000 >> a;
      Pu_types::Load_halfword: be = a[1] ? 4'b0011 : 4'b1100;
      Pu_types::Load_word:     be = 4'b1111;
      default:                 be = 4'b0000;
    endcase
    return be;
  endfunction

  function automatic logic [31:0] lane_wdata(input Pu_types::Load_mode m, input logic [31:0] w);
    logic [31:0] r;
    case (m)
      Pu_types::Load_byte:     r = {4{w[7:0]}};
      Pu_types::Load_halfword: r = {2{w[15:0]}};
      default:                 r = w;
    endcase
    return r;
  endfunction

  // Byte 0 lives in bits 31:24 (big-endian lane order).
  function automatic logic [31:0] load_extract(input Pu_types::Load_mode m, input logic [1:0] a,
                                               input logic sx, input logic [31:0] d);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    case (a)
      2'd0:    b = d[31:24];
      2'd1:    b = d[23:16];
      2'd2:    b = d[15:8];
      default: b = d[7:0];
    endcase
    h = a[1] ? d[15:0] : d[31:16];
    case (m)
      Pu_types::Load_byte:     r = {{24{sx & b[7]}}, b};
      Pu_types::Load_halfword: r = {{16{sx & h[15]}}, h};
      default:                 r = d;
    endcase
    return r;
  endfunction

`ifdef LS_MISALIGN_CHECK_EN
  assign misalign = do_request &&
                    (((mode == Pu_types::Load_halfword) && addr[0]) ||
                     ((mode == Pu_types::Load_word) && (addr[1:0] != 2'b00)));
`else
  assign misalign = 1'b0;
`endif

  assign timeout     = (WAIT_MAX != 0) && (cnt_q == CntLast);
  assign load_data   = load_extract(mode_q, addr_q[1:0], exts_q, dmem_rdata);
  assign load_result = ret_q ? load_data : addr_q;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    addr_d      = addr_q;
    we_d        = we_q;
    mode_d      = mode_q;
    exts_d      = exts_q;
    ret_d       = ret_q;
    be_d        = be_q;
    wdata_d     = wdata_q;
    res_valid_d = 1'b0;
    res_err_d   = 1'b0;
    res_data_d  = '0;

    unique case (state_q)
      StIdle: begin
        if (en_dec && (mode != Pu_types::Load_null)) begin
          cnt_d = '0;
          if (misalign) begin
            res_valid_d = 1'b1;
            res_err_d   = 1'b1;
          end else if (do_request) begin
            state_d = StReq;
            addr_d  = addr;
            we_d    = we;
            mode_d  = mode;
            exts_d  = exts;
            ret_d   = return_dout;
            be_d    = lane_be(mode, addr[1:0]);
            wdata_d = lane_wdata(mode, wdata);
          end else if (!return_dout) begin
            res_valid_d = 1'b1;
            res_data_d  = addr;
          end
        end
      end

      StReq: begin
        if (dmem_ack && we_q) begin
          state_d = StIdle;
          if (!ret_q) begin
            res_valid_d = 1'b1;
            res_data_d  = addr_q;
          end
        end else if (dmem_ack && dmem_rvalid) begin
          state_d     = StIdle;
          res_valid_d = 1'b1;
          res_err_d   = dmem_err;
          res_data_d  = load_result;
        end else if (timeout) begin
          state_d     = StIdle;
          res_valid_d = 1'b1;
          res_err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + CntW'(1);
          if (dmem_ack) begin
            state_d = StWait;
          end
        end
      end

      StWait: begin
        if (dmem_rvalid) begin
          state_d     = StIdle;
          res_valid_d = 1'b1;
          res_err_d   = dmem_err;
          res_data_d  = load_result;
        end else if (timeout) begin
          state_d     = StIdle;
          res_valid_d = 1'b1;
          res_err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      addr_q      <= '0;
      we_q        <= 1'b0;
      mode_q      <= Pu_types::Load_null;
      exts_q      <= 1'b0;
      ret_q       <= 1'b0;
      be_q        <= '0;
      wdata_q     <= '0;
      res_valid_q <= 1'b0;
      res_err_q   <= 1'b0;
      res_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      addr_q      <= addr_d;
      we_q        <= we_d;
      mode_q      <= mode_d;
      exts_q      <= exts_d;
      ret_q       <= ret_d;
      be_q        <= be_d;
      wdata_q     <= wdata_d;
      res_valid_q <= res_valid_d;
      res_err_q   <= res_err_d;
      res_data_q  <= res_data_d;
    end
  end

  assign stall      = (state_q != StIdle);
  assign dmem_req   = (state_q == StReq);
  assign dmem_we    = dmem_req & we_q;
  assign dmem_addr  = {addr_q[31:2], 2'b00};
  assign dmem_be    = be_q;
  assign dmem_wdata = wdata_q;
  assign res_valid  = res_valid_q;
  assign res_err    = res_err_q;
  assign res_data   = res_data_q;

endmodule

// File: tb/tb_ls_mem_req.sv
// Directed bench for ls_mem_req built with WAIT_MAX=4; honours LS_MISALIGN_CHECK_EN if defined.

module tb_ls_mem_req;

  logic               clk;
  logic               reset;
  logic               en_dec;
  logic               we;
  Pu_types::Load_mode mode;
  logic               return_dout;
  logic               exts;
  logic               do_request;
  logic [31:0]        addr;
  logic [31:0]        wdata;
  logic               stall;
  logic               dmem_req;
  logic               dmem_we;
  logic [31:0]        dmem_addr;
  logic [3:0]         dmem_be;
  logic [31:0]        dmem_wdata;
  logic               dmem_ack;
  logic               dmem_rvalid;
  logic               dmem_err;
  logic [31:0]        dmem_rdata;
  logic               res_valid;
  logic               res_err;
  logic [31:0]        res_data;

  int tests = 0;
  int fails = 0;

  ls_mem_req #(.WAIT_MAX(4)) dut (
    .clk         (clk),
    .reset       (reset),
    .en_dec      (en_dec),
    .we          (we),
    .mode        (mode),
    .return_dout (return_dout),
    .exts        (exts),
    .do_request  (do_request),
    .addr        (addr),
    .wdata       (wdata),
    .stall       (stall),
    .dmem_req    (dmem_req),
    .dmem_we     (dmem_we),
    .dmem_addr   (dmem_addr),
    .dmem_be     (dmem_be),
    .dmem_wdata  (dmem_wdata),
    .dmem_ack    (dmem_ack),
    .dmem_rvalid (dmem_rvalid),
    .dmem_err    (dmem_err),
    .dmem_rdata  (dmem_rdata),
    .res_valid   (res_valid),
    .res_err     (res_err),
    .res_data    (res_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents one op for a single accept edge, then withdraws en_dec.
  task automatic issue(input logic w, input Pu_types::Load_mode m, input logic ret,
                       input logic sx, input logic req, input logic [31:0] a,
                       input logic [31:0] wd);
    en_dec      = 1'b1;
    we          = w;
    mode        = m;
    return_dout = ret;
    exts        = sx;
    do_request  = req;
    addr        = a;
    wdata       = wd;
    tick();
    en_dec      = 1'b0;
  endtask

  task automatic test_reset();
    reset       = 1'b1;
    en_dec      = 1'b0;
    we          = 1'b0;
    mode        = Pu_types::Load_null;
    return_dout = 1'b0;
    exts        = 1'b0;
    do_request  = 1'b0;
    addr        = '0;
    wdata       = '0;
    dmem_ack    = 1'b0;
    dmem_rvalid = 1'b0;
    dmem_err    = 1'b0;
    dmem_rdata  = '0;
    tick();
    tick();
    tests++; if (stall !== 1'b0) begin fails++; $display("FAIL reset_stall: got %b want 0", stall); end
    tests++; if (dmem_req !== 1'b0 || dmem_we !== 1'b0) begin
      fails++; $display("FAIL reset_req_we: got %b%b want 00", dmem_req, dmem_we); end
    tests++; if (dmem_addr !== 32'h0 || dmem_be !== 4'h0 || dmem_wdata !== 32'h0) begin
      fails++; $display("FAIL reset_bus: got %h %b %h want 0", dmem_addr, dmem_be, dmem_wdata); end
    tests++; if (res_valid !== 1'b0 || res_err !== 1'b0 || res_data !== 32'h0) begin
      fails++; $display("FAIL reset_res: got %b %b %h want 0", res_valid, res_err, res_data); end
    #2 reset = 1'b0;
    tick();
  endtask

  task automatic test_byte_load();
    issue(1'b0, Pu_types::Load_byte, 1'b1, 1'b1, 1'b1, 32'h0000_1001, 32'h0);
    tests++; if (dmem_req !== 1'b1 || dmem_we !== 1'b0 || stall !== 1'b1) begin
      fails++; $display("FAIL bload_req: got req=%b we=%b stall=%b want 1 0 1",
                        dmem_req, dmem_we, stall); end
    tests++; if (dmem_addr !== 32'h0000_1000 || dmem_be !== 4'b0100) begin
      fails++; $display("FAIL bload_addr_be: got %h %b want 00001000 0100", dmem_addr, dmem_be); end
    dmem_ack    = 1'b1;
    dmem_rvalid = 1'b1;
    dmem_rdata  = 32'h1180_2233;
    tick();
    dmem_ack    = 1'b0;
    dmem_rvalid = 1'b0;
    tests++; if (res_valid !== 1'b1 || res_data !== 32'hFFFF_FF80 || res_err !== 1'b0) begin
      fails++; $display("FAIL bload_result: got v=%b d=%h e=%b want 1 ffffff80 0",
                        res_valid, res_data, res_err); end
    tests++; if (stall !== 1'b0 || dmem_req !== 1'b0) begin
      fails++; $display("FAIL bload_idle: got stall=%b req=%b want 0 0", stall, dmem_req); end
    tick();
  endtask

  task automatic test_half_store();
    issue(1'b1, Pu_types::Load_halfword, 1'b1, 1'b0, 1'b1, 32'h0000_2002, 32'hABCD_1234);
    for (int i = 0; i < 3; i++) begin
      tests++; if (dmem_req !== 1'b1 || stall !== 1'b1 || dmem_we !== 1'b1) begin
        fails++; $display("FAIL hstore_hold[%0d]: got req=%b stall=%b we=%b want 1 1 1",
                          i, dmem_req, stall, dmem_we); end
      tests++; if (dmem_addr !== 32'h0000_2000 || dmem_be !== 4'b0011 ||
                   dmem_wdata !== 32'h1234_1234) begin
        fails++; $display("FAIL hstore_bus[%0d]: got %h %b %h want 00002000 0011 12341234",
                          i, dmem_addr, dmem_be, dmem_wdata); end
      if (i == 2) dmem_ack = 1'b1;
      tick();
    end
    dmem_ack = 1'b0;
    tests++; if (dmem_req !== 1'b0 || stall !== 1'b0 || res_valid !== 1'b0) begin
      fails++; $display("FAIL hstore_done: got req=%b stall=%b v=%b want 0 0 0",
                        dmem_req, stall, res_valid); end
    tick();
  endtask

  task automatic test_store_update();
    issue(1'b1, Pu_types::Load_byte, 1'b0, 1'b0, 1'b1, 32'h0000_0083, 32'h0000_005A);
    tests++; if (dmem_be !== 4'b0001 || dmem_wdata !== 32'h5A5A_5A5A) begin
      fails++; $display("FAIL bstore_bus: got %b %h want 0001 5a5a5a5a", dmem_be, dmem_wdata); end
    dmem_ack = 1'b1;
    tick();
    dmem_ack = 1'b0;
    tests++; if (res_valid !== 1'b1 || res_data !== 32'h0000_0083 || res_err !== 1'b0) begin
      fails++; $display("FAIL bstore_result: got v=%b d=%h e=%b want 1 00000083 0",
                        res_valid, res_data, res_err); end
    tick();
  endtask

  task automatic test_update_load();
    issue(1'b0, Pu_types::Load_word, 1'b0, 1'b0, 1'b0, 32'h0000_0040, 32'h0);
    tests++; if (res_valid !== 1'b1 || res_data !== 32'h0000_0040) begin
      fails++; $display("FAIL upd_result: got v=%b d=%h want 1 00000040", res_valid, res_data); end
    tests++; if (dmem_req !== 1'b0 || stall !== 1'b0) begin
      fails++; $display("FAIL upd_noreq: got req=%b stall=%b want 0 0", dmem_req, stall); end
    tick();
    tests++; if (res_valid !== 1'b0) begin
      fails++; $display("FAIL upd_pulse: got %b want 0", res_valid); end
  endtask

  task automatic test_load_null_and_idle_resp();
    issue(1'b0, Pu_types::Load_null, 1'b0, 1'b0, 1'b1, 32'h0000_0100, 32'h0);
    tests++; if (dmem_req !== 1'b0 || stall !== 1'b0 || res_valid !== 1'b0) begin
      fails++; $display("FAIL null_op: got req=%b stall=%b v=%b want 0 0 0",
                        dmem_req, stall, res_valid); end
    dmem_ack    = 1'b1;
    dmem_rvalid = 1'b1;
    tick();
    dmem_ack    = 1'b0;
    dmem_rvalid = 1'b0;
    tick();
    tests++; if (res_valid !== 1'b0 || stall !== 1'b0) begin
      fails++; $display("FAIL idle_resp: got v=%b stall=%b want 0 0", res_valid, stall); end
  endtask

  task automatic test_half_load_err();
    issue(1'b0, Pu_types::Load_halfword, 1'b1, 1'b0, 1'b1, 32'h0000_0006, 32'h0);
    tests++; if (dmem_be !== 4'b0011 || dmem_addr !== 32'h0000_0004) begin
      fails++; $display("FAIL hload_bus: got %b %h want 0011 00000004", dmem_be, dmem_addr); end
    dmem_ack = 1'b1;
    tick();
    dmem_ack = 1'b0;
    tests++; if (stall !== 1'b1 || dmem_req !== 1'b0 || res_valid !== 1'b0) begin
      fails++; $display("FAIL hload_wait: got stall=%b req=%b v=%b want 1 0 0",
                        stall, dmem_req, res_valid); end
    dmem_rvalid = 1'b1;
    dmem_err    = 1'b1;
    dmem_rdata  = 32'h1234_8765;
    tick();
    dmem_rvalid = 1'b0;
    dmem_err    = 1'b0;
    tests++; if (res_valid !== 1'b1 || res_data !== 32'h0000_8765 || res_err !== 1'b1) begin
      fails++; $display("FAIL hload_result: got v=%b d=%h e=%b want 1 00008765 1",
                        res_valid, res_data, res_err); end
    tick();
  endtask

  task automatic test_timeout();
    issue(1'b0, Pu_types::Load_word, 1'b1, 1'b0, 1'b1, 32'h0000_0100, 32'h0);
    for (int i = 0; i < 4; i++) begin
      tests++; if (dmem_req !== 1'b1 || res_valid !== 1'b0) begin
        fails++; $display("FAIL tmo_req[%0d]: got req=%b v=%b want 1 0", i, dmem_req, res_valid); end
      tick();
    end
    tests++; if (res_valid !== 1'b1 || res_err !== 1'b1 || res_data !== 32'h0) begin
      fails++; $display("FAIL tmo_result: got v=%b e=%b d=%h want 1 1 00000000",
                        res_valid, res_err, res_data); end
    tests++; if (dmem_req !== 1'b0 || stall !== 1'b0) begin
      fails++; $display("FAIL tmo_idle: got req=%b stall=%b want 0 0", dmem_req, stall); end
    tick();
  endtask

  task automatic test_reset_in_wait();
    issue(1'b0, Pu_types::Load_byte, 1'b1, 1'b0, 1'b1, 32'h0000_0020, 32'h0);
    dmem_ack = 1'b1;
    tick();
    dmem_ack = 1'b0;
    reset = 1'b1;
    #2;
    tests++; if (stall !== 1'b0 || dmem_req !== 1'b0) begin
      fails++; $display("FAIL rst_wait_abort: got stall=%b req=%b want 0 0", stall, dmem_req); end
    reset = 1'b0;
    dmem_rvalid = 1'b1;
    dmem_rdata  = 32'h5555_5555;
    tick();
    dmem_rvalid = 1'b0;
    tests++; if (res_valid !== 1'b0) begin
      fails++; $display("FAIL rst_late_resp: got %b want 0", res_valid); end
    issue(1'b0, Pu_types::Load_word, 1'b1, 1'b0, 1'b1, 32'h0000_0010, 32'h0);
    tests++; if (dmem_addr !== 32'h0000_0010 || dmem_be !== 4'b1111) begin
      fails++; $display("FAIL wload_bus: got %h %b want 00000010 1111", dmem_addr, dmem_be); end
    dmem_ack = 1'b1;
    tick();
    dmem_ack    = 1'b0;
    dmem_rvalid = 1'b1;
    dmem_rdata  = 32'hDEAD_BEEF;
    tick();
    dmem_rvalid = 1'b0;
    tests++; if (res_valid !== 1'b1 || res_data !== 32'hDEAD_BEEF || res_err !== 1'b0) begin
      fails++; $display("FAIL wload_result: got v=%b d=%h e=%b want 1 deadbeef 0",
                        res_valid, res_data, res_err); end
    // Back-to-back: accept a new op while the previous result is pulsing.
    issue(1'b0, Pu_types::Load_word, 1'b0, 1'b0, 1'b0, 32'h0000_0044, 32'h0);
    tests++; if (res_valid !== 1'b1 || res_data !== 32'h0000_0044) begin
      fails++; $display("FAIL b2b_result: got v=%b d=%h want 1 00000044", res_valid, res_data); end
    tick();
  endtask

  task automatic test_misalign();
    issue(1'b0, Pu_types::Load_word, 1'b1, 1'b0, 1'b1, 32'h0000_0003, 32'h0);
`ifdef LS_MISALIGN_CHECK_EN
    tests++; if (res_valid !== 1'b1 || res_err !== 1'b1 || res_data !== 32'h0) begin
      fails++; $display("FAIL misalign_err: got v=%b e=%b d=%h want 1 1 00000000",
                        res_valid, res_err, res_data); end
    tests++; if (dmem_req !== 1'b0 || stall !== 1'b0) begin
      fails++; $display("FAIL misalign_noreq: got req=%b stall=%b want 0 0", dmem_req, stall); end
`else
    tests++; if (dmem_req !== 1'b1 || dmem_addr !== 32'h0 || dmem_be !== 4'b1111) begin
      fails++; $display("FAIL unaligned_bus: got req=%b %h %b want 1 00000000 1111",
                        dmem_req, dmem_addr, dmem_be); end
    dmem_ack    = 1'b1;
    dmem_rvalid = 1'b1;
    dmem_rdata  = 32'hCAFE_F00D;
    tick();
    dmem_ack    = 1'b0;
    dmem_rvalid = 1'b0;
    tests++; if (res_valid !== 1'b1 || res_data !== 32'hCAFE_F00D || res_err !== 1'b0) begin
      fails++; $display("FAIL unaligned_result: got v=%b d=%h e=%b want 1 cafef00d 0",
                        res_valid, res_data, res_err); end
`endif
    tick();
  endtask

  initial begin
    test_reset();
    test_byte_load();
    test_half_store();
    test_store_update();
    test_update_load();
    test_load_null_and_idle_resp();
    test_half_load_err();
    test_timeout();
    test_reset_in_wait();
    test_misalign();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/ls_mem_req.md
LS_MEM_REQ -- requirements
Module: ls_mem_req

Interface
REQ-001 Parameter WAIT_MAX, default 255: maximum cycles spent in REQ plus WAIT before a timeout; 0 disables the timeout.
REQ-002 clk  in  1  single clock; all state updates on posedge clk.
REQ-003 reset  in  1  asynchronous, active-high reset.
REQ-004 en_dec  in  1  decoded load/store op present this cycle.
REQ-005 we  in  1  1 = store, 0 = load.
REQ-006 mode  in  Pu_types::Load_mode  access size: Load_null, Load_byte, Load_halfword or Load_word.
REQ-007 return_dout  in  1  1 = result is memory data; 0 = result is the effective address (update forms).
REQ-008 exts  in  1  sign-extend loaded data.
REQ-009 do_request  in  1  1 = a memory access is required.
REQ-010 addr  in  32  effective address.
REQ-011 wdata  in  32  store data, right-justified.
REQ-012 stall  out  1  upstream hold; combinational, equals (state != IDLE).
REQ-013 dmem_req, dmem_we  out  1 each  bus request valid and write strobe.
REQ-014 dmem_addr  out  32  {addr[31:2], 2'b00}.
REQ-015 dmem_be  out  4  byte enables; be[3] is bits 31:24 (big-endian byte 0).
REQ-016 dmem_wdata  out  32  lane-replicated store data.
REQ-017 dmem_ack, dmem_rvalid, dmem_err  in  1 each  request accepted; read data valid; bus error qualified by dmem_rvalid.
REQ-018 dmem_rdata  in  32  read data.
REQ-019 res_valid, res_err  out  1 each  single-cycle result pulse; error flag.
REQ-020 res_data  out  32  result value.

Function
REQ-021 The FSM SHALL have states IDLE, REQ and WAIT, and SHALL accept an op only in IDLE with en_dec=1.
REQ-022 An op with mode=Load_null SHALL issue no request and produce no result.
REQ-023 do_request=0 with return_dout=0: res_valid=1 and res_data=addr one cycle after accept; the FSM stays in IDLE.
REQ-024 do_request=1: the FSM enters REQ and dmem_req=1 from the cycle after accept. Address, we, be and wdata SHALL be registered and held stable until dmem_ack.
REQ-025 Store ack: the FSM returns to IDLE. If return_dout=0, a res_valid pulse with res_data=addr SHALL be produced in the cycle after ack; otherwise no result.
REQ-026 Load ack: the FSM enters WAIT. If dmem_rvalid is asserted in the ack cycle, the FSM SHALL go directly to IDLE with the result.
REQ-027 Load rvalid: the FSM returns to IDLE and asserts res_valid the next cycle with res_err=dmem_err.
REQ-028 Load extraction: byte = rdata[31-8*a : 24-8*a] with a=addr[1:0]; halfword = rdata[31:16] when addr[1]=0, else rdata[15:0].
REQ-029 Loaded data SHALL be zero-extended unless exts=1, in which case it is sign-extended.
REQ-030 Store lanes: byte -> wdata[7:0] replicated x4, be one-hot at lane a; halfword -> wdata[15:0] x2, be=4'b1100 or 4'b0011 by addr[1]; word -> be=4'b1111.
REQ-031 The cycle counter SHALL clear on accept and count in REQ and WAIT. When it reaches WAIT_MAX (WAIT_MAX≠0), the block SHALL go to IDLE and pulse res_valid with res_err=1 and res_data=0, and dmem_req SHALL drop.
REQ-032 dmem_rvalid and dmem_ack seen in IDLE SHALL be ignored.
REQ-033 A new op SHALL be accepted in the same cycle that res_valid pulses.

Reset
REQ-034 On reset, state=IDLE, the counter=0, and all outputs=0 (stall=0, dmem_*=0, res_*=0).
REQ-035 Reset during REQ or WAIT SHALL abandon the op; a response arriving later SHALL be discarded.

Configuration
REQ-036 With LS_MISALIGN_CHECK_EN defined, a halfword access with addr[0]=1 or a word access with addr[1:0]≠0 SHALL issue no request and SHALL produce res_valid=1, res_err=1, res_data=0 one cycle after accept.
REQ-037 Without LS_MISALIGN_CHECK_EN, the low address bits not used by REQ-028/030 SHALL be ignored and no misalign error SHALL be raised.

Verification
REQ-038 Byte load: addr=0x1001, exts=1, dmem_rdata=0x1180_2233, ack and rvalid in the same cycle -> res_data=0xFFFF_FF80, res_err=0.
REQ-039 Halfword store: addr=0x2002, wdata=0xABCD_1234 -> dmem_addr=0x2000, be=0011, dmem_wdata=0x1234_1234; dmem_req held for 3 cycles until ack; stall=1 throughout.
REQ-040 Update load: do_request=0, return_dout=0, addr=0x40 -> res_valid one cycle later with res_data=0x40; no dmem_req.
REQ-041 Timeout: WAIT_MAX=4, ack never asserted -> res_err=1 after 4 cycles, dmem_req=0, FSM in IDLE.
REQ-042 Reset in WAIT, then rvalid arrives -> no res_valid; a following word load at 0x10 completes normally.
REQ-043 With LS_MISALIGN_CHECK_EN: word load at 0x3 -> res_err=1, no dmem_req; without the macro -> dmem_addr=0x0 and normal completion.
